nano_ctrl: RTL and testbench
============================

Name: nano_ctrl

Overview:
Sequencer for the 8-bit accumulator nanoprocessor. It fetches two-byte instructions from the synchronous RAM and feeds the ALU (instruction code, accumulator, RAM operand, carry in). It registers the ALU result, carry and zero flags, and handles store, jumps and halt. It sits between the RAM and the combinational ALU and owns the PC, IR, accumulator and flags.

Parameters:
PC_RESET, 8'h00, PC value after reset.
HALT_ON_ILLEGAL, 0, when 1 an undefined class halts the core; when 0 it executes as NOP.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  synchronous active-low reset
ram_addr  out  8  RAM address
ram_rdata  in  8  RAM read data, valid one cycle after ram_addr
ram_wdata  out  8  RAM write data (always the accumulator)
ram_we  out  1  RAM write strobe, one cycle
alu_i  out  4  ALU operation code
alu_a  out  8  ALU operand A (accumulator)
alu_b  out  8  ALU operand B (equals ram_rdata)
alu_cin  out  1  ALU carry in (carry flag)
alu_s  in  8  ALU result
alu_cout  in  1  ALU carry out
alu_z  in  1  ALU zero
acc  out  8  accumulator (debug)
pc  out  8  program counter (debug)
halted  out  1  core is in HALT

Behaviour:
- Instruction layout: byte0 at PC; class = [7:4], ALU code = [3:0]. Byte1 at PC+1 is the operand address.
- Class values: 0 = ALU op, 1 = STORE, 2 = JMP, 3 = JMPC (jump if C=1), 4 = JMPZ (jump if Z=1), 5 = HALT, 6-15 = illegal.
- Reset (reset_n=0 at an edge): state=FETCH_OP, pc=PC_RESET, acc=0, C=0, Z=0, ir=0, ram_we=0, halted=0. Reset mid-instruction aborts it; no partial write survives.
- FETCH_OP: ram_addr=pc. Next state is FETCH_ARG.
- FETCH_ARG: ir<=ram_rdata; ram_addr=pc+1 (8-bit wrap). Next state is DECODE.
- DECODE (ram_rdata = operand address), pc<=pc+2 (wraps mod 256), then by class:
  - ALU: ram_addr=ram_rdata, next EXEC.
  - STORE: ram_addr=ram_rdata, ram_we=1, ram_wdata=acc, next FETCH_OP. Flags unchanged.
  - JMP: pc<=ram_rdata, which overrides pc+2.
  - JMPC/JMPZ: pc<=ram_rdata only if the flag is set, else pc+2. Next FETCH_OP.
  - HALT: next HALT; pc still advances by 2.
  - Illegal: NOP, or HALT when HALT_ON_ILLEGAL=1.
- EXEC: alu_i=ir[3:0], alu_b=ram_rdata. At the edge: acc<=alu_s, C<=alu_cout, Z<=alu_z. Next FETCH_OP.
- HALT: halted=1, no RAM access, ram_we=0. Left only by reset.
- Latency: ALU instruction 4 cycles; STORE, jump, NOP 3 cycles.
- Outside EXEC: alu_i=ir[3:0], alu_a=acc, alu_cin=C, alu_b=ram_rdata. ALU outputs are ignored.
- ram_we is high only in a DECODE cycle for STORE. ram_addr/ram_we are combinational from state; all other state is registered.

Optional Feature:
NANO_SINGLE_STEP_EN.
- With the macro: adds input port step (1 bit). FETCH_OP holds, with ram_addr=pc and no state change, until step=1 is sampled. One instruction then executes per step pulse. A held step runs freely.
- Without the macro: no step port; FETCH_OP always advances.

Decomposition:
- Package nano_pkg holds:
  - state_t enum: FETCH_OP, FETCH_ARG, DECODE, EXEC, HALT.
  - Class constants: CL_ALU, CL_STORE, CL_JMP, CL_JMPC, CL_JMPZ, CL_HALT.
  - Widths: DATA_W=8, ADDR_W=8.
- No sub-module needed. Optional: a nano_core top wrapper instancing nano_ctrl plus the ALU.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with PC_RESET=8'h10 -> pc=8'h10, acc=0, halted=0, ram_we=0, first ram_addr=8'h10.
- ALU op: mem[0]=8'h0k (ALU code k = add), mem[1]=8'h20, mem[20]=8'h05, acc=8'hFE -> after 4 cycles acc=8'h03, C=1, Z=0, pc=2.
- STORE: acc=8'h3C, instr 8'h10,8'h40 -> exactly one cycle with ram_we=1, ram_addr=8'h40, ram_wdata=8'h3C; flags unchanged; pc+2.
- Conditional jump: Z=1, instr 8'h40,8'h80 -> pc=8'h80. Same with Z=0 -> pc=old+2. Same for JMPC with C.
- Wrap/halt: instr at pc=8'hFE is 8'h20,8'h05 -> pc=8'h05. Instr 8'h50 at pc=8'hFE -> halted=1, pc=8'h00, no further ram_we.
- Reset mid-EXEC and illegal class 8'hF0: acc unchanged after reset → 0. Illegal class acts as NOP (pc+2), or halts when HALT_ON_ILLEGAL=1.

Source files
------------

// File: rtl/nano_pkg.sv
// nano_pkg: shared states, instruction classes and widths for the nanoprocessor (rev 1.0)
`default_nettype none

package nano_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  typedef enum logic [2:0] {
    FETCH_OP  = 3'd0,
    FETCH_ARG = 3'd1,
    DECODE    = 3'd2,
    EXEC      = 3'd3,
    HALT      = 3'd4
  } state_t;

  localparam logic [3:0] CL_ALU   = 4'd0;
  localparam logic [3:0] CL_STORE = 4'd1;
  localparam logic [3:0] CL_JMP   = 4'd2;
  localparam logic [3:0] CL_JMPC  = 4'd3;
  localparam logic [3:0] CL_JMPZ  = 4'd4;
  localparam logic [3:0] CL_HALT  = 4'd5;

endpackage

`default_nettype wire

// File: rtl/nano_ctrl.sv
// nano_ctrl: fetch/decode/exec sequencer owning PC, IR, ACC and C/Z flags (rev 1.0).
// Optional NANO_SINGLE_STEP_EN adds a step input that gates each instruction fetch.
`default_nettype none

module nano_ctrl
  import nano_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PC_RESET        = 8'h00,
  parameter bit                HALT_ON_ILLEGAL = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef NANO_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic [3:0]        alu_i,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_s,
  input  logic              alu_cout,
  input  logic              alu_z,
  output logic [DATA_W-1:0] acc,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc_n;
  logic [DATA_W-1:0]   ir, ir_n, acc_n;
  logic                c, c_n, z, z_n;
  logic [ADDR_W-1:0]   addr_c;
  logic                we_c;
  logic                go;

`ifdef NANO_SINGLE_STEP_EN
  assign go = step;
`else
  assign go = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= FETCH_OP;
      pc    <= PC_RESET;
      ir    <= '0;
      acc   <= '0;
      c     <= 1'b0;
      z     <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ir    <= ir_n;
      acc   <= acc_n;
      c     <= c_n;
      z     <= z_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    acc_n   = acc;
    c_n     = c;
    z_n     = z;
    addr_c  = pc;
    we_c    = 1'b0;
    case (state)
      FETCH_OP: begin
        if (go) state_n = FETCH_ARG;
      end
      FETCH_ARG: begin
        addr_c  = pc + 8'd1;
        ir_n    = ram_rdata;
        state_n = DECODE;
      end
      DECODE: begin
        // ram_rdata here is the operand address fetched from pc+1
        addr_c  = ram_rdata;
        pc_n    = pc + 8'd2;
        state_n = FETCH_OP;
        case (ir[7:4])
          CL_ALU:   state_n = EXEC;
          CL_STORE: we_c = 1'b1;
          CL_JMP:   pc_n = ram_rdata;
          CL_JMPC:  if (c) pc_n = ram_rdata;
          CL_JMPZ:  if (z) pc_n = ram_rdata;
          CL_HALT:  state_n = HALT;
          default:  if (HALT_ON_ILLEGAL) state_n = HALT;
        endcase
      end
      EXEC: begin
        acc_n   = alu_s;
        c_n     = alu_cout;
        z_n     = alu_z;
        state_n = FETCH_OP;
      end
      HALT: begin
        state_n = HALT;
      end
      default: state_n = FETCH_OP;
    endcase
  end

  // Masking with reset keeps an aborted STORE from reaching the RAM
  assign ram_we    = we_c & reset_n;
  assign ram_addr  = addr_c;
  assign ram_wdata = acc;
  assign alu_i     = ir[3:0];
  assign alu_a     = acc;
  assign alu_b     = ram_rdata;
  assign alu_cin   = c;
  assign halted    = (state == HALT);

endmodule

`default_nettype wire

// File: tb/tb_nano_ctrl.sv
// tb_nano_ctrl: RAM + ALU environment with a write scoreboard for nano_ctrl (rev 1.0)
`default_nettype none

module tb_nano_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] ram_addr, ram_rdata, ram_wdata;
  logic       ram_we;
  logic [3:0] alu_i;
  logic [7:0] alu_a, alu_b, alu_s, acc, pc;
  logic       alu_cin, alu_cout, alu_z, halted;

  logic [7:0] mem [256];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [15:0] wr_q [$];

  always #5 clk = ~clk;

  nano_ctrl #(.PC_RESET(8'h10), .HALT_ON_ILLEGAL(1'b0)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef NANO_SINGLE_STEP_EN
    .step      (1'b1),
`endif
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .alu_i     (alu_i),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cin   (alu_cin),
    .alu_s     (alu_s),
    .alu_cout  (alu_cout),
    .alu_z     (alu_z),
    .acc       (acc),
    .pc        (pc),
    .halted    (halted)
  );

  // Synchronous RAM: read data valid one cycle after the address
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  // ALU: 0 add, 1 add with carry, 4 pass B, others XOR
  always_comb begin
    case (alu_i)
      4'd0:    {alu_cout, alu_s} = {1'b0, alu_a} + {1'b0, alu_b};
      4'd1:    {alu_cout, alu_s} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
      4'd4:    {alu_cout, alu_s} = {1'b0, alu_b};
      default: {alu_cout, alu_s} = {1'b0, alu_a ^ alu_b};
    endcase
    alu_z = (alu_s == 8'd0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write
  always @(negedge clk) begin
    if (reset_n && ram_we) begin
      if (wr_q.size() == 0) begin
        chk("we_unexpected", {31'd0, ram_we}, 32'd0);
      end else begin
        logic [15:0] e;
        e = wr_q.pop_front();
        chk("we_addr", {24'd0, ram_addr}, {24'd0, e[15:8]});
        chk("we_data", {24'd0, ram_wdata}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic put(input logic [7:0] a, input logic [7:0] b0, input logic [7:0] b1);
    mem[a]         = b0;
    mem[a + 8'd1]  = b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    clear_mem();
    do_reset();
    chk("rst_pc", {24'd0, pc}, 32'h10);
    chk("rst_acc", {24'd0, acc}, 32'h0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_we", {31'd0, ram_we}, 32'd0);
    chk("rst_addr", {24'd0, ram_addr}, 32'h10);

    // ALU op with carry, then JMPZ not taken and JMPC taken
    clear_mem();
    put(8'h10, 8'h04, 8'h30); put(8'h12, 8'h00, 8'h20);
    put(8'h14, 8'h40, 8'h80); put(8'h16, 8'h30, 8'h80);
    mem[8'h30] = 8'hFE; mem[8'h20] = 8'h05;
    do_reset();
    run(4);
    chk("ld_acc", {24'd0, acc}, 32'hFE);
    chk("ld_pc", {24'd0, pc}, 32'h12);
    chk("ld_c", {31'd0, alu_cin}, 32'd0);
    run(4);
    chk("add_acc", {24'd0, acc}, 32'h03);
    chk("add_c", {31'd0, alu_cin}, 32'd1);
    chk("add_pc", {24'd0, pc}, 32'h14);
    run(3);
    chk("jmpz_nt_pc", {24'd0, pc}, 32'h16);
    run(3);
    chk("jmpc_t_pc", {24'd0, pc}, 32'h80);

    // STORE with C=1 left untouched
    clear_mem();
    put(8'h10, 8'h04, 8'h30); put(8'h12, 8'h00, 8'h31); put(8'h14, 8'h10, 8'h40);
    mem[8'h30] = 8'hFF; mem[8'h31] = 8'h3D;
    do_reset();
    run(8);
    chk("st_pre_acc", {24'd0, acc}, 32'h3C);
    wr_q.push_back({8'h40, 8'h3C});
    run(3);
    chk("st_pc", {24'd0, pc}, 32'h16);
    chk("st_c", {31'd0, alu_cin}, 32'd1);
    chk("st_acc", {24'd0, acc}, 32'h3C);
    chk("st_mem", {24'd0, mem[8'h40]}, 32'h3C);

    // JMPZ taken, JMPC not taken
    clear_mem();
    put(8'h10, 8'h04, 8'h32); put(8'h12, 8'h40, 8'h80); put(8'h80, 8'h30, 8'h50);
    do_reset();
    run(4);
    chk("z_acc", {24'd0, acc}, 32'h0);
    run(3);
    chk("jmpz_t_pc", {24'd0, pc}, 32'h80);
    run(3);
    chk("jmpc_nt_pc", {24'd0, pc}, 32'h82);

    // Operand fetch wraps from FF to 00 is not needed; JMP at FE reads FF
    clear_mem();
    put(8'h10, 8'h20, 8'hFE); put(8'hFE, 8'h20, 8'h05);
    do_reset();
    run(3);
    chk("jmp_pc", {24'd0, pc}, 32'hFE);
    run(3);
    chk("jmp_wrap_pc", {24'd0, pc}, 32'h05);

    // HALT at FE: pc wraps to 00 and the STORE there never runs
    clear_mem();
    put(8'h10, 8'h20, 8'hFE); put(8'hFE, 8'h50, 8'h00); put(8'h00, 8'h10, 8'h44);
    do_reset();
    run(6);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_pc", {24'd0, pc}, 32'h00);
    run(10);
    chk("halt_hold", {31'd0, halted}, 32'd1);
    chk("halt_hold_pc", {24'd0, pc}, 32'h00);
    chk("halt_mem", {24'd0, mem[8'h44]}, 32'h00);

    // Reset during EXEC drops the result; illegal class is a NOP
    clear_mem();
    put(8'h10, 8'h04, 8'h30);
    mem[8'h30] = 8'h77;
    do_reset();
    run(3);
    put(8'h10, 8'hF0, 8'h30); put(8'h12, 8'h04, 8'h30);
    do_reset();
    chk("rst_exec_acc", {24'd0, acc}, 32'h0);
    chk("rst_exec_pc", {24'd0, pc}, 32'h10);
    run(3);
    chk("ill_pc", {24'd0, pc}, 32'h12);
    chk("ill_halted", {31'd0, halted}, 32'd0);
    chk("ill_acc", {24'd0, acc}, 32'h0);
    run(4);
    chk("post_ill_acc", {24'd0, acc}, 32'h77);

    @(negedge clk);
    chk("sb_empty", wr_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
